// File: rtl/leg_alu_issue.sv
// Instruction sequencer for the LEG 8-bit ALU: fetches 4-byte instructions,
// resolves operands, drives the ALU and retires the result to a register, PC or output port.
module leg_alu_issue #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       pm_rd,
    output logic [7:0] pm_addr,
    input  logic [7:0] pm_rdata,
    input  logic       pm_valid,
    output logic [2:0] rf_raddr0,
    input  logic [7:0] rf_rdata0,
    output logic [2:0] rf_raddr1,
    input  logic [7:0] rf_rdata1,
    output logic [7:0] alu_opcode,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    input  logic [7:0] alu_result,
    output logic       rf_we,
    output logic [2:0] rf_waddr,
    output logic [7:0] rf_wdata,
    input  logic [7:0] io_in,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [7:0] pc,
    output logic       busy,
    output logic       retire,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_F3, S_DEC, S_EXEC, S_WB
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_opcode;
    logic [7:0] r_arg1;
    logic [7:0] r_arg2;
    logic [2:0] r_dest;
    logic [7:0] r_result;
    logic       r_pm_rd;
    logic [7:0] r_pm_addr;
    logic [2:0] r_raddr0;
    logic [2:0] r_raddr1;
    logic [7:0] r_alu_opcode;
    logic [7:0] r_alu_op1;
    logic [7:0] r_alu_op2;
    logic       r_rf_we;
    logic [2:0] r_rf_waddr;
    logic [7:0] r_rf_wdata;
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic       r_retire;
    logic       r_illegal;

    logic       w_illegal;
    logic [7:0] w_op1;
    logic [7:0] w_op2;
    logic [7:0] w_pc_next;

    // Source index 0-5 = register file, 6 = current PC, 7 = input port.
    function automatic logic [7:0] resolve(input logic imm, input logic [7:0] arg,
                                           input logic [7:0] rdata, input logic [7:0] cur_pc,
                                           input logic [7:0] io);
        if (imm)                  return arg;
        else if (arg[2:0] == 3'd6) return cur_pc;
        else if (arg[2:0] == 3'd7) return io;
        else                      return rdata;
    endfunction

    assign w_illegal = (r_opcode[5:4] != 2'b00);
    assign w_op1     = resolve(r_opcode[7], r_arg1, rf_rdata0, r_pc, io_in);
    assign w_op2     = resolve(r_opcode[6], r_arg2, rf_rdata1, r_pc, io_in);
    assign w_pc_next = (!w_illegal && r_dest == 3'd6) ? r_result : r_pc + 8'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_opcode     <= '0;
            r_arg1       <= '0;
            r_arg2       <= '0;
            r_dest       <= '0;
            r_result     <= '0;
            r_pm_rd      <= 1'b0;
            r_pm_addr    <= RESET_PC;
            r_raddr0     <= '0;
            r_raddr1     <= '0;
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_retire     <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_rf_we     <= 1'b0;
            r_out_valid <= 1'b0;
            r_retire    <= 1'b0;
            r_illegal   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state   <= S_F0;
                        r_pm_rd   <= 1'b1;
                        r_pm_addr <= r_pc;
                    end
                end
                S_F0: if (pm_valid) begin
                    r_opcode  <= pm_rdata;
                    r_pm_addr <= r_pm_addr + 8'd1;
                    r_state   <= S_F1;
                end
                S_F1: if (pm_valid) begin
                    r_arg1    <= pm_rdata;
                    r_pm_addr <= r_pm_addr + 8'd1;
                    r_state   <= S_F2;
                end
                S_F2: if (pm_valid) begin
                    r_arg2    <= pm_rdata;
                    r_pm_addr <= r_pm_addr + 8'd1;
                    r_state   <= S_F3;
                end
                S_F3: if (pm_valid) begin
                    r_dest   <= pm_rdata[2:0];
                    r_pm_rd  <= 1'b0;
                    r_raddr0 <= r_arg1[2:0];
                    r_raddr1 <= r_arg2[2:0];
                    r_state  <= S_DEC;
                end
                // ALU input registers double as the operand latches, so they are valid throughout EXEC.
                S_DEC: begin
                    r_alu_opcode <= r_opcode;
                    r_alu_op1    <= w_op1;
                    r_alu_op2    <= w_op2;
                    r_state      <= S_EXEC;
                end
                S_EXEC: begin
                    r_result  <= alu_result;
                    r_retire  <= 1'b1;
                    r_illegal <= w_illegal;
                    if (!w_illegal) begin
                        if (r_dest <= 3'd5) begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_dest;
                            r_rf_wdata <= alu_result;
                        end else if (r_dest == 3'd7) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= alu_result;
                        end
                    end
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_pc      <= w_pc_next;
                    r_pm_addr <= w_pc_next;
                    if (run) begin
                        r_state <= S_F0;
                        r_pm_rd <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pm_rd      = r_pm_rd;
    assign pm_addr    = r_pm_addr;
    assign rf_raddr0  = r_raddr0;
    assign rf_raddr1  = r_raddr1;
    assign alu_opcode = r_alu_opcode;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign pc         = r_pc;
    assign busy       = (r_state != S_IDLE);
    assign retire     = r_retire;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_leg_alu_issue.sv
// Directed bench for leg_alu_issue with a behavioural program memory,
// register file and LEG ALU around the sequencer.
module tb_leg_alu_issue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       pm_rd;
    logic [7:0] pm_addr;
    logic [7:0] pm_rdata;
    logic       pm_valid;
    logic [2:0] rf_raddr0, rf_raddr1, rf_waddr;
    logic [7:0] rf_rdata0, rf_rdata1;
    logic [7:0] alu_opcode, alu_op1, alu_op2, alu_result;
    logic       rf_we;
    logic [7:0] rf_wdata;
    logic [7:0] io_in = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] pc;
    logic       busy, retire, illegal;

    logic [7:0] mem [256];
    logic [7:0] rf  [8];
    int         wait_cyc = 0;
    int         wcnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    // Captured by run_instr
    int         n_cyc;
    logic       got, saw_we, saw_ov;
    logic       cap_we, cap_ov, cap_ill;
    logic [2:0] cap_waddr;
    logic [7:0] cap_wdata, cap_odata, cap_op1, cap_op2;
    logic [7:0] fa [4];
    int         nfetch;
    logic       chk_hold = 1'b0;

    always #5 clk = ~clk;

    leg_alu_issue #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .run(run),
        .pm_rd(pm_rd), .pm_addr(pm_addr), .pm_rdata(pm_rdata), .pm_valid(pm_valid),
        .rf_raddr0(rf_raddr0), .rf_rdata0(rf_rdata0),
        .rf_raddr1(rf_raddr1), .rf_rdata1(rf_rdata1),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .io_in(io_in), .out_valid(out_valid), .out_data(out_data),
        .pc(pc), .busy(busy), .retire(retire), .illegal(illegal)
    );

    assign pm_valid  = pm_rd && (wcnt >= wait_cyc);
    assign pm_rdata  = mem[pm_addr];
    assign rf_rdata0 = rf[rf_raddr0];
    assign rf_rdata1 = rf[rf_raddr1];

    always @(posedge clk) begin
        if (pm_rd && !pm_valid) wcnt <= wcnt + 1;
        else                    wcnt <= 0;
        if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    always_comb begin
        alu_result = 8'h00;
        case (alu_opcode[3:0])
            4'h0: alu_result = alu_op1 + alu_op2;
            4'h1: alu_result = alu_op1 - alu_op2;
            4'h2: alu_result = alu_op1 & alu_op2;
            4'h3: alu_result = alu_op1 | alu_op2;
            4'h4: alu_result = ~alu_op1;
            4'h5: alu_result = alu_op1 ^ alu_op2;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] p;
        p = a;
        mem[p] = b0; p = p + 8'd1;
        mem[p] = b1; p = p + 8'd1;
        mem[p] = b2; p = p + 8'd1;
        mem[p] = b3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issues one instruction from IDLE; run drops after edge drop_at, then one more edge into IDLE.
    task automatic run_instr(input int drop_at);
        logic       prev_wait;
        logic [7:0] prev_addr;
        n_cyc = 0; got = 0; saw_we = 0; saw_ov = 0; nfetch = 0;
        prev_wait = 0; prev_addr = 8'h00;
        @(negedge clk);
        run = 1'b1;
        while (n_cyc < 60 && !got) begin
            @(posedge clk); #1;
            n_cyc++;
            if (n_cyc == drop_at) run = 1'b0;
            if (pm_rd && pm_valid && nfetch < 4) begin
                fa[nfetch] = pm_addr;
                nfetch++;
            end
            if (chk_hold && prev_wait) check_eq("addr_hold", pm_addr, prev_addr);
            prev_wait = pm_rd && !pm_valid;
            prev_addr = pm_addr;
            if (rf_we) saw_we = 1;
            if (out_valid) saw_ov = 1;
            if (retire) begin
                got = 1;
                cap_we = rf_we; cap_ov = out_valid; cap_ill = illegal;
                cap_waddr = rf_waddr; cap_wdata = rf_wdata; cap_odata = out_data;
                cap_op1 = alu_op1; cap_op2 = alu_op2;
            end
        end
        if (!got) check_eq("retire_timeout", 0, 1);
        run = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        rst = 1'b0;
        #12;
        check_eq("rst_pc", pc, 8'h00);
        check_eq("rst_pm_addr", pm_addr, 8'h00);
        check_eq("rst_pm_rd", pm_rd, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_retire", retire, 0);
        check_eq("rst_we", rf_we, 0);
        check_eq("rst_alu_op1", alu_op1, 8'h00);
        @(negedge clk); rst = 1'b1;

        // 1: ADD r1+r2 -> r3
        rf[1] = 8'd5; rf[2] = 8'd7;
        load4(8'h00, 8'h00, 8'h01, 8'h02, 8'h03);
        run_instr(1);
        check_eq("t1_cycles", n_cyc, 7);
        check_eq("t1_we", cap_we, 1);
        check_eq("t1_waddr", cap_waddr, 3);
        check_eq("t1_wdata", cap_wdata, 8'd12);
        check_eq("t1_ill", cap_ill, 0);
        check_eq("t1_pc", pc, 8'h04);
        check_eq("t1_pm_addr", pm_addr, 8'h04);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_rf3", rf[3], 8'd12);

        // 2: SUB immediates -> r0
        load4(8'h04, 8'hC1, 8'h0A, 8'h03, 8'h00);
        run_instr(1);
        check_eq("t2_op1", cap_op1, 8'd10);
        check_eq("t2_op2", cap_op2, 8'd3);
        check_eq("t2_waddr", cap_waddr, 0);
        check_eq("t2_wdata", cap_wdata, 8'd7);
        check_eq("t2_rf0", rf[0], 8'd7);
        check_eq("t2_pc", pc, 8'h08);

        // 3: jump via dest 6, then output port with io_in source
        do_reset();
        load4(8'h00, 8'hC0, 8'h08, 8'h00, 8'h06);
        run_instr(1);
        check_eq("t3_retire", got, 1);
        check_eq("t3_no_we", saw_we, 0);
        check_eq("t3_pc", pc, 8'h08);
        check_eq("t3_pm_addr", pm_addr, 8'h08);
        io_in = 8'd3;
        load4(8'h08, 8'h80, 8'h09, 8'h07, 8'h07);
        run_instr(1);
        check_eq("t3_ov", cap_ov, 1);
        check_eq("t3_odata", cap_odata, 8'd12);
        check_eq("t3_no_we2", saw_we, 0);
        check_eq("t3_pc2", pc, 8'h0C);

        // 4: illegal opcode
        do_reset();
        load4(8'h00, 8'h20, 8'h01, 8'h02, 8'h03);
        run_instr(1);
        check_eq("t4_ill", cap_ill, 1);
        check_eq("t4_no_we", saw_we, 0);
        check_eq("t4_no_ov", saw_ov, 0);
        check_eq("t4_pc", pc, 8'h04);

        // 5: three wait cycles per byte
        do_reset();
        load4(8'h00, 8'h00, 8'h01, 8'h02, 8'h03);
        wait_cyc = 3; chk_hold = 1'b1;
        run_instr(1);
        wait_cyc = 0; chk_hold = 1'b0;
        check_eq("t5_cycles", n_cyc, 19);
        check_eq("t5_wdata", cap_wdata, 8'd12);
        check_eq("t5_waddr", cap_waddr, 3);
        check_eq("t5_pc", pc, 8'h04);

        // 5b: reset asserted in EXEC aborts the instruction
        do_reset();
        rf[3] = 8'hAA;
        @(negedge clk); run = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) run = 1'b0;
        end
        rst = 1'b0;
        #1;
        check_eq("t5b_pc", pc, 8'h00);
        check_eq("t5b_pm_addr", pm_addr, 8'h00);
        check_eq("t5b_busy", busy, 0);
        check_eq("t5b_opc", alu_opcode, 8'h00);
        check_eq("t5b_op1", alu_op1, 8'h00);
        saw_we = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (rf_we || retire) saw_we = 1;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (rf_we || retire) saw_we = 1;
        end
        check_eq("t5b_no_wr", saw_we, 0);
        check_eq("t5b_rf3", rf[3], 8'hAA);

        // 6: jump to FC, fetch wraps, PC source, run dropped in DEC
        do_reset();
        load4(8'h00, 8'hC0, 8'hFC, 8'h00, 8'h06);
        run_instr(1);
        check_eq("t6_pc_fc", pc, 8'hFC);
        load4(8'hFC, 8'h41, 8'h06, 8'h01, 8'h01);
        run_instr(5);
        check_eq("t6_cycles", n_cyc, 7);
        check_eq("t6_fa0", fa[0], 8'hFC);
        check_eq("t6_fa1", fa[1], 8'hFD);
        check_eq("t6_fa2", fa[2], 8'hFE);
        check_eq("t6_fa3", fa[3], 8'hFF);
        check_eq("t6_wdata", cap_wdata, 8'hFB);
        check_eq("t6_pc_wrap", pc, 8'h00);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_rf1", rf[1], 8'hFB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
